oscill_stepper: RTL and testbench



---
 rtl/oscill_pkg.sv | 47 ++++
 rtl/oscill_stepper_if.sv | 27 ++
 rtl/oscill_rk_stage.sv | 36 +++
 rtl/oscill_stepper.sv | 135 +++++++++++++
 tb/tb_oscill_stepper.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/oscill_pkg.sv
// Shared types, defaults and arithmetic helpers for the RK4 oscillator stepper.
// Build option OSCILL_SAT_EN: saturating stage/update arithmetic instead of wrap-around.
package oscill_pkg;

   localparam int W_DEF        = 8;
   localparam int CW_DEF       = 16;
   localparam int DIV_HALF_DEF = 40;
   localparam int DIV_MID_DEF  = 60;
   localparam int DIV_END_DEF  = 120;

   typedef enum logic [2:0] {IDLE, S1, S2, S3, S4, UPD, EMIT} state_t;

   typedef logic signed [W_DEF-1:0] data_t;

   function automatic int satAdd(input int a, input int b, input int w);
      int lo;
      int hi;
      int s;
      lo = -(1 << (w - 1));
      hi = (1 << (w - 1)) - 1;
      s  = a + b;
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction

   function automatic int wrapW(input int x, input int w);
      int m;
      m = x & ((1 << w) - 1);
      if (m >= (1 << (w - 1))) m = m - (1 << w);
      return m;
   endfunction

   // Every stage/update add goes through here so the build option switches all of them together.
   function automatic int addOp(input int a, input int b, input int w);
`ifdef OSCILL_SAT_EN
      return satAdd(a, b, w);
`else
      return wrapW(a + b, w);
`endif
   endfunction

   function automatic int negOp(input int a, input int w);
      return addOp(0, -a, w);
   endfunction

endpackage

// File: rtl/oscill_stepper_if.sv
// Control and sample-stream bundle between the stepper (slave) and its driver/consumer (master).
interface oscill_stepper_if import oscill_pkg::*; #(
   parameter int W  = W_DEF,
   parameter int CW = CW_DEF
);
   logic                 start;
   logic signed [W-1:0]  y1_init;
   logic signed [W-1:0]  y2_init;
   logic [CW-1:0]        n_steps;
   logic                 busy;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [W-1:0]  out_y1;
   logic signed [W-1:0]  out_y2;
   logic [CW-1:0]        out_idx;
   logic                 done;

   modport master (
      output start, y1_init, y2_init, n_steps, out_ready,
      input  busy, out_valid, out_y1, out_y2, out_idx, done
   );

   modport slave (
      input  start, y1_init, y2_init, n_steps, out_ready,
      output busy, out_valid, out_y1, out_y2, out_idx, done
   );
endinterface

// File: rtl/oscill_rk_stage.sv
// Combinational evaluation of one RK4 stage of dy1/dt = y2, dy2/dt = -y1.
// Stage select 0..3 picks k1/g1, the two half-step stages, or the full-step stage.
module oscill_rk_stage import oscill_pkg::*; #(
   parameter int W        = W_DEF,
   parameter int DIV_HALF = DIV_HALF_DEF
) (
   input  logic signed [W-1:0] i_y1,
   input  logic signed [W-1:0] i_y2,
   input  logic signed [W-1:0] i_k,
   input  logic signed [W-1:0] i_g,
   input  logic [1:0]          i_sel,
   output logic signed [W-1:0] o_k,
   output logic signed [W-1:0] o_g
);

   // i_k/i_g are the previous stage's increments; the first stage ignores them.
   always_comb begin
      o_k = '0;
      o_g = '0;
      case (i_sel)
         2'd0: begin
            o_k = i_y2;
            o_g = W'(negOp(int'(i_y1), W));
         end
         2'd1, 2'd2: begin
            o_k = W'(addOp(int'(i_y2), int'(i_g) / DIV_HALF, W));
            o_g = W'(negOp(addOp(int'(i_y1), int'(i_k) / DIV_HALF, W), W));
         end
         default: begin
            o_k = W'(addOp(int'(i_y2), int'(i_g), W));
            o_g = W'(negOp(addOp(int'(i_y1), int'(i_k), W), W));
         end
      endcase
   end

endmodule

// File: rtl/oscill_stepper.sv
// Sequential RK4 driver for the harmonic oscillator: four stage cycles, an update
// cycle, then a valid/ready sample hand-off, repeated for the programmed step count.
module oscill_stepper import oscill_pkg::*; #(
   parameter int W        = W_DEF,
   parameter int CW       = CW_DEF,
   parameter int DIV_HALF = DIV_HALF_DEF,
   parameter int DIV_MID  = DIV_MID_DEF,
   parameter int DIV_END  = DIV_END_DEF
) (
   input logic           clk,
   input logic           rst,
   oscill_stepper_if.slave bus
);

   state_t               r_state;
   logic signed [W-1:0]  r_y1, r_y2;
   logic signed [W-1:0]  r_k [4];
   logic signed [W-1:0]  r_g [4];
   logic [CW-1:0]        r_idx, r_nSteps;
   logic                 r_busy, r_outValid, r_done;
   logic signed [W-1:0]  r_outY1, r_outY2;
   logic [CW-1:0]        r_outIdx;

   logic [1:0]           w_sel;
   state_t               w_stageNext;
   logic signed [W-1:0]  w_kPrev, w_gPrev, w_kNew, w_gNew;
   logic signed [W-1:0]  w_y1Next, w_y2Next;
   int                   w_kSum, w_gSum;

   assign w_kPrev = r_k[w_sel - 2'd1];
   assign w_gPrev = r_g[w_sel - 2'd1];

   oscill_rk_stage #(.W(W), .DIV_HALF(DIV_HALF)) u_stage (
      .i_y1  (r_y1),
      .i_y2  (r_y2),
      .i_k   (w_kPrev),
      .i_g   (w_gPrev),
      .i_sel (w_sel),
      .o_k   (w_kNew),
      .o_g   (w_gNew)
   );

   // Each quotient truncates on its own before the sum; the sum itself stays well inside W bits.
   always_comb begin
      w_sel       = 2'd0;
      w_stageNext = S2;
      case (r_state)
         S2:      begin w_sel = 2'd1; w_stageNext = S3;  end
         S3:      begin w_sel = 2'd2; w_stageNext = S4;  end
         S4:      begin w_sel = 2'd3; w_stageNext = UPD; end
         default: ;
      endcase
      w_kSum = int'(r_k[0]) / DIV_END + int'(r_k[1]) / DIV_MID
             + int'(r_k[2]) / DIV_MID + int'(r_k[3]) / DIV_END;
      w_gSum = int'(r_g[0]) / DIV_END + int'(r_g[1]) / DIV_MID
             + int'(r_g[2]) / DIV_MID + int'(r_g[3]) / DIV_END;
      w_y1Next = W'(addOp(int'(r_y1), w_kSum, W));
      w_y2Next = W'(addOp(int'(r_y2), w_gSum, W));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_y1       <= '0;
         r_y2       <= '0;
         for (int i = 0; i < 4; i++) begin
            r_k[i] <= '0;
            r_g[i] <= '0;
         end
         r_idx      <= '0;
         r_nSteps   <= '0;
         r_busy     <= 1'b0;
         r_outValid <= 1'b0;
         r_done     <= 1'b0;
         r_outY1    <= '0;
         r_outY2    <= '0;
         r_outIdx   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.n_steps != '0) begin
                     r_y1     <= bus.y1_init;
                     r_y2     <= bus.y2_init;
                     r_nSteps <= bus.n_steps;
                     r_idx    <= '0;
                     r_busy   <= 1'b1;
                     r_state  <= S1;
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            S1, S2, S3, S4: begin
               r_k[w_sel] <= w_kNew;
               r_g[w_sel] <= w_gNew;
               r_state    <= w_stageNext;
            end
            UPD: begin
               r_y1       <= w_y1Next;
               r_y2       <= w_y2Next;
               r_idx      <= r_idx + CW'(1);
               r_outY1    <= w_y1Next;
               r_outY2    <= w_y2Next;
               r_outIdx   <= r_idx + CW'(1);
               r_outValid <= 1'b1;
               r_state    <= EMIT;
            end
            EMIT: begin
               // Holding here under backpressure is what stalls the integrator.
               if (bus.out_ready) begin
                  r_outValid <= 1'b0;
                  if (r_idx == r_nSteps) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     r_state <= S1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.out_valid = r_outValid;
   assign bus.out_y1    = r_outY1;
   assign bus.out_y2    = r_outY2;
   assign bus.out_idx   = r_outIdx;
   assign bus.done      = r_done;

endmodule

// File: tb/tb_oscill_stepper.sv
// Directed self-checking bench for oscill_stepper: timing, backpressure, restart, reset and edge values.
module tb_oscill_stepper;
   import oscill_pkg::*;

   localparam int W  = 8;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int assertCount = 0;
   int failCount   = 0;
   int doneCount   = 0;
   int expY1 [1:16];
   int expY2 [1:16];

   always #5 clk = ~clk;

   oscill_stepper_if #(.W(W), .CW(CW)) bus ();

   oscill_stepper #(.W(W), .CW(CW), .DIV_HALF(40), .DIV_MID(60), .DIV_END(120)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   function automatic int fixW(input int x);
      int r;
`ifdef OSCILL_SAT_EN
      r = (x > 127) ? 127 : ((x < -128) ? -128 : x);
`else
      r = x % 256;
      if (r > 127) r = r - 256;
      if (r < -128) r = r + 256;
`endif
      return r;
   endfunction

   task automatic modelStep(input int y1, input int y2, output int ny1, output int ny2);
      int k1, k2, k3, k4, g1, g2, g3, g4;
      k1 = y2;                     g1 = fixW(-y1);
      k2 = fixW(y2 + g1 / 40);     g2 = fixW(-fixW(y1 + k1 / 40));
      k3 = fixW(y2 + g2 / 40);     g3 = fixW(-fixW(y1 + k2 / 40));
      k4 = fixW(y2 + g3);          g4 = fixW(-fixW(y1 + k3));
      ny1 = fixW(y1 + k1 / 120 + k2 / 60 + k3 / 60 + k4 / 120);
      ny2 = fixW(y2 + g1 / 120 + g2 / 60 + g3 / 60 + g4 / 120);
   endtask

   task automatic buildExpected(input int y1, input int y2, input int n);
      int a, b;
      for (int i = 1; i <= n; i++) begin
         modelStep(y1, y2, a, b);
         expY1[i] = a;
         expY2[i] = b;
         y1 = a;
         y2 = b;
      end
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.done) doneCount++;
   endtask

   task automatic applyStimulus(input int y1, input int y2, input int n);
      bus.y1_init = W'(y1);
      bus.y2_init = W'(y2);
      bus.n_steps = CW'(n);
      bus.start   = 1'b1;
      tick();
      bus.start   = 1'b0;
   endtask

   task automatic waitValid(input string tag, input int budget);
      int k;
      k = 0;
      while (!bus.out_valid && k < budget) begin
         tick();
         k++;
      end
      checkOutput({tag, "_arrive"}, int'(bus.out_valid), 1);
   endtask

   task automatic checkSample(input string tag, input int y1, input int y2, input int idx);
      checkOutput({tag, "_y1"}, int'(bus.out_y1), y1);
      checkOutput({tag, "_y2"}, int'(bus.out_y2), y2);
      checkOutput({tag, "_idx"}, int'(bus.out_idx), idx);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      int d0;
      int sawValid;

      bus.start     = 1'b0;
      bus.y1_init   = '0;
      bus.y2_init   = '0;
      bus.n_steps   = '0;
      bus.out_ready = 1'b1;

      // Reset state
      tick();
      tick();
      checkOutput("rst_valid", int'(bus.out_valid), 0);
      checkOutput("rst_busy",  int'(bus.busy), 0);
      checkOutput("rst_done",  int'(bus.done), 0);
      checkSample("rst", 0, 0, 0);
      rst = 1'b0;
      tick();

      // Single step from (0,120): valid on the sixth cycle after start
      applyStimulus(0, 120, 1);
      checkOutput("t1_busy", int'(bus.busy), 1);
      sawValid = 0;
      repeat (4) begin
         tick();
         if (bus.out_valid) sawValid = 1;
      end
      checkOutput("t1_early_valid", sawValid, 0);
      tick();
      checkOutput("t1_valid", int'(bus.out_valid), 1);
      checkSample("t1", 5, 119, 1);
      checkOutput("t1_done_early", int'(bus.done), 0);
      tick();
      checkOutput("t1_done", int'(bus.done), 1);
      checkOutput("t1_valid_drop", int'(bus.out_valid), 0);
      checkOutput("t1_busy_drop", int'(bus.busy), 0);
      tick();
      checkOutput("t1_done_pulse", int'(bus.done), 0);

      // Zero-length run: done only, no samples
      applyStimulus(5, 5, 0);
      checkOutput("t0_done", int'(bus.done), 1);
      checkOutput("t0_busy", int'(bus.busy), 0);
      tick();
      checkOutput("t0_done_pulse", int'(bus.done), 0);
      checkOutput("t0_valid", int'(bus.out_valid), 0);

      // Three steps from rest
      d0 = doneCount;
      applyStimulus(0, 0, 3);
      for (int i = 1; i <= 3; i++) begin
         waitValid("t2", 10);
         checkSample("t2", 0, 0, i);
         tick();
      end
      tick();
      checkOutput("t2_done_count", doneCount - d0, 1);
      checkOutput("t2_busy", int'(bus.busy), 0);

      // Four steps with a ten-cycle stall on sample 2
      buildExpected(0, 120, 4);
      checkOutput("t3_model_first_y1", expY1[1], 5);
      d0 = doneCount;
      applyStimulus(0, 120, 4);
      waitValid("t3_s1", 10);
      checkSample("t3_s1", expY1[1], expY2[1], 1);
      tick();
      bus.out_ready = 1'b0;
      waitValid("t3_s2", 10);
      for (int c = 0; c < 10; c++) begin
         checkOutput("t3_stall_valid", int'(bus.out_valid), 1);
         checkOutput("t3_stall_busy", int'(bus.busy), 1);
         checkSample("t3_stall", expY1[2], expY2[2], 2);
         tick();
      end
      bus.out_ready = 1'b1;
      checkSample("t3_s2", expY1[2], expY2[2], 2);
      tick();
      checkOutput("t3_s2_taken", int'(bus.out_valid), 0);
      for (int i = 3; i <= 4; i++) begin
         waitValid("t3", 10);
         checkSample("t3", expY1[i], expY2[i], i);
         tick();
      end
      tick();
      checkOutput("t3_done_count", doneCount - d0, 1);
      checkOutput("t3_busy", int'(bus.busy), 0);

      // Restart attempts while busy are ignored
      buildExpected(0, 120, 3);
      d0 = doneCount;
      applyStimulus(0, 120, 3);
      tick();
      bus.y1_init = 8'sd50;
      bus.y2_init = -8'sd30;
      bus.n_steps = 16'd7;
      bus.start   = 1'b1;
      tick();
      bus.start   = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         waitValid("t4", 10);
         checkSample("t4", expY1[i], expY2[i], i);
         bus.start = 1'b1;
         tick();
         bus.start = 1'b0;
      end
      sawValid = 0;
      repeat (8) begin
         tick();
         if (bus.out_valid) sawValid = 1;
      end
      checkOutput("t4_no_extra", sawValid, 0);
      checkOutput("t4_done_count", doneCount - d0, 1);
      checkOutput("t4_busy", int'(bus.busy), 0);

      // Reset during S3 of step 2
      applyStimulus(0, 120, 4);
      waitValid("t5", 10);
      tick();
      tick();
      tick();
      d0 = doneCount;
      rst = 1'b1;
      #1;
      checkOutput("t5_valid", int'(bus.out_valid), 0);
      checkOutput("t5_busy", int'(bus.busy), 0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      checkOutput("t5_no_done", doneCount - d0, 0);
      applyStimulus(0, 120, 1);
      waitValid("t5_fresh", 10);
      checkSample("t5_fresh", 5, 119, 1);
      tick();

      // Reset while a sample is being held drops out_valid at once
      bus.out_ready = 1'b0;
      applyStimulus(0, 120, 2);
      waitValid("t6", 10);
      rst = 1'b1;
      #1;
      checkOutput("t6_valid_drop", int'(bus.out_valid), 0);
      tick();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      tick();

      // Extreme initial values
      applyStimulus(127, 127, 1);
      waitValid("t7", 10);
`ifdef OSCILL_SAT_EN
      checkSample("t7", 127, 121, 1);
`else
      checkSample("t7", -128, -126, 1);
`endif
      tick();
      tick();

      buildExpected(-128, 0, 2);
      applyStimulus(-128, 0, 2);
      for (int i = 1; i <= 2; i++) begin
         waitValid("t8", 10);
         checkSample("t8", expY1[i], expY2[i], i);
         tick();
      end
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
